// File: rtl/voice_allocator_pkg.sv
// Shared types and constants for the voice allocator and its voice picker.
package voice_allocator_pkg;

    localparam int VOICES_DEFAULT    = 4;
    localparam int NOTE_BITS_DEFAULT = 7;
    localparam int AGE_BITS_DEFAULT  = 4;

    localparam logic [AGE_BITS_DEFAULT-1:0] AGE_MAX = '1;

    localparam int VIDX_BITS = (VOICES_DEFAULT > 1) ? $clog2(VOICES_DEFAULT) : 1;

    typedef logic [NOTE_BITS_DEFAULT-1:0] note_t;
    typedef logic [VIDX_BITS-1:0]         voice_idx_t;

    // Allocator sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECIDE,
        ST_DROP,
        ST_RAISE
    } state_t;

    // How the picked voice relates to the incoming note-on.
    typedef enum logic [1:0] {
        PICK_RETRIG,
        PICK_FREE,
        PICK_RELEASE,
        PICK_STEAL
    } pick_t;

endpackage

// File: rtl/voice_allocator_picker.sv
// Combinational voice selection for a note-on: retrigger, then lowest free,
// then oldest releasing, then oldest gated. Age ties go to the lowest index.
module voice_allocator_picker
    import voice_allocator_pkg::*;
#(
    parameter int VOICES    = VOICES_DEFAULT,
    parameter int NOTE_BITS = NOTE_BITS_DEFAULT,
    parameter int AGE_BITS  = AGE_BITS_DEFAULT,
    parameter int IDX_W     = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic [VOICES-1:0]           gate,
    input  logic [VOICES-1:0]           active,
    input  logic [VOICES*NOTE_BITS-1:0] voice_note,
    input  logic [VOICES*AGE_BITS-1:0]  ages,
    input  logic [NOTE_BITS-1:0]        note,
    output logic [IDX_W-1:0]            target,
    output pick_t                       pick_class
);

    logic                found_retrig, found_free, found_rel;
    logic [IDX_W-1:0]    idx_retrig, idx_free, idx_rel, idx_steal;
    logic [AGE_BITS-1:0] age_rel, age_steal;
    logic                found_steal;

    // Scan every voice once, keeping the best candidate of each class.
    always_comb begin
        found_retrig = 1'b0;
        found_free   = 1'b0;
        found_rel    = 1'b0;
        found_steal  = 1'b0;
        idx_retrig   = '0;
        idx_free     = '0;
        idx_rel      = '0;
        idx_steal    = '0;
        age_rel      = '0;
        age_steal    = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (gate[i] && voice_note[i*NOTE_BITS +: NOTE_BITS] == note && !found_retrig) begin
                found_retrig = 1'b1;
                idx_retrig   = IDX_W'(i);
            end
            if (!gate[i] && !active[i] && !found_free) begin
                found_free = 1'b1;
                idx_free   = IDX_W'(i);
            end
            // Strict compare keeps the lowest index on an age tie.
            if (!gate[i] && active[i] && (!found_rel || ages[i*AGE_BITS +: AGE_BITS] > age_rel)) begin
                found_rel = 1'b1;
                idx_rel   = IDX_W'(i);
                age_rel   = ages[i*AGE_BITS +: AGE_BITS];
            end
            if (gate[i] && (!found_steal || ages[i*AGE_BITS +: AGE_BITS] > age_steal)) begin
                found_steal = 1'b1;
                idx_steal   = IDX_W'(i);
                age_steal   = ages[i*AGE_BITS +: AGE_BITS];
            end
        end
    end

    // Every voice lands in exactly one class, so one of the four always exists.
    always_comb begin
        target     = idx_steal;
        pick_class = PICK_STEAL;
        if (found_retrig) begin
            target     = idx_retrig;
            pick_class = PICK_RETRIG;
        end else if (found_free) begin
            target     = idx_free;
            pick_class = PICK_FREE;
        end else if (found_rel) begin
            target     = idx_rel;
            pick_class = PICK_RELEASE;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony controller: accepts note-on/off events and drives gate and note
// for a bank of envelope voices, guaranteeing a fresh gate edge per note-on.
// Optional sustain pedal support: define VOICE_ALLOCATOR_SUSTAIN_PEDAL_EN.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int VOICES    = VOICES_DEFAULT,
    parameter int NOTE_BITS = NOTE_BITS_DEFAULT,
    parameter int AGE_BITS  = AGE_BITS_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ev_valid,
    output logic                        ev_ready,
    input  logic                        ev_on,
    input  logic [NOTE_BITS-1:0]        ev_note,
    input  logic [VOICES-1:0]           active,
`ifdef VOICE_ALLOCATOR_SUSTAIN_PEDAL_EN
    input  logic                        sustain,
`endif
    output logic [VOICES-1:0]           gate,
    output logic [VOICES*NOTE_BITS-1:0] voice_note
);

    localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

    state_t                     state_reg, state_next;
    logic                       on_reg;
    logic [NOTE_BITS-1:0]       note_reg;
    logic [IDX_W-1:0]           target_reg;
    logic [IDX_W-1:0]           pick_idx;
    pick_t                      pick_class;
    logic [VOICES*AGE_BITS-1:0] ages_flat;

`ifdef VOICE_ALLOCATOR_SUSTAIN_PEDAL_EN
    logic sustain_d_reg;
    logic sustain_fall;
    assign sustain_fall = sustain_d_reg & ~sustain;

    // Remember last sustain level to spot the pedal release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sustain_d_reg <= 1'b0;
        else       sustain_d_reg <= sustain;
    end
`endif

    voice_allocator_picker #(
        .VOICES    (VOICES),
        .NOTE_BITS (NOTE_BITS),
        .AGE_BITS  (AGE_BITS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .gate       (gate),
        .active     (active),
        .voice_note (voice_note),
        .ages       (ages_flat),
        .note       (note_reg),
        .target     (pick_idx),
        .pick_class (pick_class)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic; the allocator only listens while idle.
    always_comb begin
        state_next = state_reg;
        ev_ready   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                ev_ready = 1'b1;
                if (ev_valid) state_next = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (!on_reg)
                    state_next = ST_IDLE;
                else if (pick_class == PICK_RETRIG || pick_class == PICK_STEAL)
                    state_next = ST_DROP;
                else
                    state_next = ST_RAISE;
            end
            ST_DROP:  state_next = ST_RAISE;
            ST_RAISE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Capture the accepted event and the voice chosen for it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            on_reg     <= 1'b0;
            note_reg   <= '0;
            target_reg <= '0;
        end else begin
            if (state_reg == ST_IDLE && ev_valid) begin
                on_reg   <= ev_on;
                note_reg <= ev_note;
            end
            if (state_reg == ST_DECIDE) target_reg <= pick_idx;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < VOICES; gi++) begin : g_voice
            logic                 v_gate_reg;
            logic [NOTE_BITS-1:0] v_note_reg;
            logic [AGE_BITS-1:0]  v_age_reg;
            logic                 is_target;
            logic                 off_hit;

            assign is_target = (target_reg == IDX_W'(gi));
            assign off_hit   = (state_reg == ST_DECIDE) && !on_reg && v_gate_reg
                               && (v_note_reg == note_reg);

            assign gate[gi]                             = v_gate_reg;
            assign voice_note[gi*NOTE_BITS +: NOTE_BITS] = v_note_reg;
            assign ages_flat[gi*AGE_BITS +: AGE_BITS]    = v_age_reg;

`ifdef VOICE_ALLOCATOR_SUSTAIN_PEDAL_EN
            logic v_held_reg;
            logic is_pick;
            assign is_pick = (pick_idx == IDX_W'(gi));

            // Gate, note and sustain-hold flag for this voice.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v_gate_reg <= 1'b0;
                    v_note_reg <= '0;
                    v_held_reg <= 1'b0;
                end else begin
                    if (off_hit) begin
                        if (sustain) begin
                            v_held_reg <= 1'b1;
                        end else begin
                            v_gate_reg <= 1'b0;
                            v_held_reg <= 1'b0;
                        end
                    end
                    if (state_reg == ST_DECIDE && on_reg && is_pick &&
                        (pick_class == PICK_RETRIG || pick_class == PICK_STEAL))
                        v_held_reg <= 1'b0;
                    if (state_reg == ST_DROP && is_target) v_gate_reg <= 1'b0;
                    if (state_reg == ST_RAISE && is_target) begin
                        v_gate_reg <= 1'b1;
                        v_note_reg <= note_reg;
                    end
                    // Pedal release wins over anything else this cycle.
                    if (sustain_fall && v_held_reg) begin
                        v_gate_reg <= 1'b0;
                        v_held_reg <= 1'b0;
                    end
                end
            end
`else
            // Gate and note for this voice.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v_gate_reg <= 1'b0;
                    v_note_reg <= '0;
                end else begin
                    if (off_hit) v_gate_reg <= 1'b0;
                    if (state_reg == ST_DROP && is_target) v_gate_reg <= 1'b0;
                    if (state_reg == ST_RAISE && is_target) begin
                        v_gate_reg <= 1'b1;
                        v_note_reg <= note_reg;
                    end
                end
            end
`endif

            // Saturating age: cleared on the voice just raised, bumped on the rest.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v_age_reg <= '1;
                end else if (state_reg == ST_RAISE) begin
                    if (is_target)
                        v_age_reg <= '0;
                    else if (v_age_reg != {AGE_BITS{1'b1}})
                        v_age_reg <= v_age_reg + 1'b1;
                end
            end
        end
    endgenerate

endmodule
